patch_streamer: RTL and testbench
=================================

PATCH_STREAMER -- requirements
Module: patch_streamer

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter K, default 3, square window size, legal range 1..7.
REQ-004 SHALL have parameter STRIDE, default 1, window step in both axes, legal range 1..K.
REQ-005 SHALL have parameter PAD, default 0, zero-pad border width, legal range 0..K-1.
REQ-006 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles, legal range 1..3.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port start, input, 1, starts a full-image scan when sampled high in IDLE.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the final patch handshake.
REQ-012 SHALL have port mem_addr, output, $clog2(IMG_W*IMG_H), read address, computed as row*IMG_W+col.
REQ-013 SHALL have port mem_rd, output, 1, read strobe; one read per cycle at most.
REQ-014 SHALL have port mem_data, input, 8, pixel returned MEM_LAT cycles after the mem_rd cycle.
REQ-015 SHALL have port patch_valid, output, 1, patch output is valid.
REQ-016 SHALL have port patch_ready, input, 1, consumer accepts the patch.
REQ-017 SHALL have port patch, output, signed 8 x K*K, window in row-major order; element 0 is top-left.
REQ-018 SHALL have port out_row, output, $clog2(IMG_H+2*PAD), output-grid row of the current patch.
REQ-019 SHALL have port out_col, output, $clog2(IMG_W+2*PAD), output-grid column of the current patch.
REQ-020 SHALL have port last, output, 1, qualifies the final patch of the scan; valid only with patch_valid.

Function
REQ-021 SHALL compute the output grid size as OUT_W=(IMG_W+2*PAD-K)/STRIDE+1 and OUT_H=(IMG_H+2*PAD-K)/STRIDE+1, using integer division.
REQ-022 SHALL visit output positions in row-major order, starting at (0,0) and ending at (OUT_H-1,OUT_W-1).
REQ-023 SHALL place the window origin in padded-image coordinates at (out_row*STRIDE-PAD, out_col*STRIDE-PAD).
REQ-024 SHALL use the following FSM states: IDLE, FETCH, DRAIN, PRESENT, FINISH.
REQ-025 SHALL move IDLE->FETCH when start=1; start SHALL be ignored in every other state.
REQ-026 SHALL, in FETCH, step the element index 0..K*K-1, one element per cycle, and then move to DRAIN.
REQ-027 SHALL, for an in-image element in FETCH, assert mem_rd and drive its address.
REQ-028 SHALL, for an out-of-image (pad) element in FETCH, deassert mem_rd and store 0 for that element.
REQ-029 SHALL tag each read with its element index through a MEM_LAT-deep pipeline and write mem_data into that element's slot.
REQ-030 SHALL stay in DRAIN for MEM_LAT cycles and then move to PRESENT with patch_valid=1.
REQ-031 SHALL hold patch, out_row, out_col and last stable in PRESENT while patch_ready=0.
REQ-032 SHALL, on patch_valid&&patch_ready, move to FINISH if last=1 and otherwise advance the position and move to FETCH on the next cycle.
REQ-033 SHALL assert done for exactly one cycle in FINISH, then return to IDLE.
REQ-034 SHALL meet this latency, with the start-sample cycle counted as cycle 0: first patch_valid at cycle K*K+MEM_LAT+1; each later patch K*K+MEM_LAT+1 cycles after the previous handshake.
REQ-035 SHALL keep mem_rd=0 outside FETCH and drive mem_addr=0 whenever mem_rd=0.
REQ-036 SHALL deassert last on every patch except position (OUT_H-1,OUT_W-1).
REQ-037 SHALL treat a patch_ready that is high before patch_valid as having no effect.
REQ-038 SHALL never issue an address at or beyond IMG_W*IMG_H.

Reset
REQ-039 SHALL, on reset=1 at a clock edge in any state, go to IDLE and clear the element index, position counters and tag pipeline.
REQ-040 SHALL, on reset, drive busy, done, mem_rd, patch_valid and last to 0, mem_addr, out_row and out_col to 0, and all patch elements to 0.
REQ-041 SHALL drop any read still in flight when reset is asserted mid-scan and SHALL NOT write it into patch.

Verification
REQ-042 SHALL be tested with IMG_W=IMG_H=4, K=3, STRIDE=1, PAD=0, MEM_LAT=1, mem[a]=a, ready held at 1 -> 4 patches; first {0,1,2,4,5,6,8,9,10} at cycle 11; last at (1,1) is {5,6,7,9,10,11,13,14,15}; done one cycle after it.
REQ-043 SHALL be tested with the same setup and PAD=1 -> 16 patches; (0,0) is {0,0,0,0,0,1,0,4,5}; (3,3) is {10,11,0,14,15,0,0,0,0}; no address above 15 issued.
REQ-044 SHALL be tested with IMG_W=IMG_H=5, STRIDE=2, PAD=0, MEM_LAT=2 -> 4 patches; (0,1) is {2,3,4,7,8,9,12,13,14}; first patch_valid at cycle 12.
REQ-045 SHALL be tested with patch_ready=0 for 5 cycles on patch (0,0) -> patch_valid, patch and coordinates stable for all 5 cycles; mem_rd=0 throughout.
REQ-046 SHALL be tested with reset pulsed in FETCH of patch 2, then start reissued -> outputs return to reset values; the rescan's first patch is again {0,1,2,4,5,6,8,9,10}.
REQ-047 SHALL be tested with start held high for the whole scan -> exactly one scan and one done pulse; a new scan begins only if start is still high in IDLE after FINISH.

Source files
------------

// File: rtl/patch_streamer.sv
// Sliding-window patch extractor: scans an IMG_H x IMG_W image held in a
// latency-MEM_LAT memory and emits zero-padded K x K windows in row-major order.
module patch_streamer #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int K       = 3,
   parameter int STRIDE  = 1,
   parameter int PAD     = 0,
   parameter int MEM_LAT = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(IMG_W*IMG_H)-1:0]      mem_addr,
   output logic                                mem_rd,
   input  logic [7:0]                          mem_data,
   output logic                                patch_valid,
   input  logic                                patch_ready,
   output logic signed [K*K-1:0][7:0]          patch,
   output logic [$clog2(IMG_H+2*PAD)-1:0]      out_row,
   output logic [$clog2(IMG_W+2*PAD)-1:0]      out_col,
   output logic                                last
);

   localparam int AW    = $clog2(IMG_W*IMG_H);
   localparam int RW    = $clog2(IMG_H+2*PAD);
   localparam int CW    = $clog2(IMG_W+2*PAD);
   localparam int NE    = K*K;
   localparam int IW    = $clog2(NE+1);
   localparam int OUT_W = (IMG_W + 2*PAD - K) / STRIDE + 1;
   localparam int OUT_H = (IMG_H + 2*PAD - K) / STRIDE + 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_DRAIN   = 3'd2;
   localparam logic [2:0] ST_PRESENT = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

   logic [2:0]                    state_q, state_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [2:0]                    er_q, er_d;
   logic [2:0]                    ec_q, ec_d;
   logic [1:0]                    drain_q, drain_d;
   logic [RW-1:0]                 row_q, row_d;
   logic [CW-1:0]                 col_q, col_d;
   logic [MEM_LAT-1:0]            tag_vld_q, tag_vld_d;
   logic [MEM_LAT-1:0][IW-1:0]    tag_idx_q, tag_idx_d;
   logic [NE-1:0][7:0]            patch_q, patch_d;

   int                            pix_row, pix_col;
   logic                          in_img;
   logic                          at_end;
   logic [AW-1:0]                 rd_addr;

   // Window element position in unpadded image coordinates; negative or
   // past-the-edge positions are padding and never reach memory.
   always_comb begin
      pix_row = int'(row_q) * STRIDE - PAD + int'(er_q);
      pix_col = int'(col_q) * STRIDE - PAD + int'(ec_q);
      in_img  = (state_q == ST_FETCH) && (pix_row >= 0) && (pix_row < IMG_H) &&
                (pix_col >= 0) && (pix_col < IMG_W);
      rd_addr = AW'(pix_row * IMG_W + pix_col);
      at_end  = (row_q == RW'(OUT_H-1)) && (col_q == CW'(OUT_W-1));
   end

   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_idx_d    = tag_idx_q;
      tag_vld_d[0] = in_img;
      tag_idx_d[0] = idx_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end

      patch_d = patch_q;
      if (tag_vld_q[MEM_LAT-1])
         patch_d[tag_idx_q[MEM_LAT-1]] = mem_data;
      if ((state_q == ST_FETCH) && !in_img)
         patch_d[idx_q] = '0;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      er_d    = er_q;
      ec_d    = ec_q;
      drain_d = drain_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               er_d    = '0;
               ec_d    = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_FETCH: begin
            if (idx_q == IW'(NE-1)) begin
               state_d = ST_DRAIN;
               drain_d = '0;
               idx_d   = '0;
               er_d    = '0;
               ec_d    = '0;
            end else begin
               idx_d = idx_q + 1'b1;
               if (ec_q == 3'(K-1)) begin
                  ec_d = '0;
                  er_d = er_q + 1'b1;
               end else begin
                  ec_d = ec_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == 2'(MEM_LAT-1))
               state_d = ST_PRESENT;
            else
               drain_d = drain_q + 1'b1;
         end
         ST_PRESENT: begin
            if (patch_ready) begin
               if (at_end) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_FETCH;
                  if (col_q == CW'(OUT_W-1)) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         er_q      <= '0;
         ec_q      <= '0;
         drain_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
         tag_vld_q <= '0;
         tag_idx_q <= '0;
         patch_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         er_q      <= er_d;
         ec_q      <= ec_d;
         drain_q   <= drain_d;
         row_q     <= row_d;
         col_q     <= col_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
         patch_q   <= patch_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FINISH);
   assign patch_valid = (state_q == ST_PRESENT);
   assign last        = patch_valid && at_end;
   assign mem_rd      = in_img;
   assign mem_addr    = in_img ? rd_addr : '0;
   assign patch       = patch_q;
   assign out_row     = row_q;
   assign out_col     = col_q;

endmodule

// File: tb/tb_patch_streamer.sv
// Directed bench: three configurations of patch_streamer (4x4 no pad, 4x4 pad 1,
// 5x5 stride 2 latency 2), each fed by a memory model holding mem[a] = a.
module tb_patch_streamer;

   logic clk = 1'b0;
   logic reset;
   logic clr;
   logic start [3];
   logic rdy   [3];
   logic busy  [3];
   logic done  [3];
   logic mrd   [3];
   logic pv    [3];
   logic last  [3];
   logic [71:0] pt [3];
   logic [3:0] addr0, addr1;
   logic [4:0] addr2;
   logic [1:0] row0, col0;
   logic [2:0] row1, col1, row2, col2;
   logic [7:0] md0, md1, md2, m2a;
   int a_i [3];
   int r_i [3];
   int c_i [3];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int s0;

   int hs_cnt   [3];
   int done_cnt [3];
   int done_cyc [3];
   int first_pv [3];
   int max_addr [3];
   int bad_cnt  [3];
   logic [71:0] lg_pt   [3][20];
   int          lg_row  [3][20];
   int          lg_col  [3][20];
   int          lg_cyc  [3][20];
   logic        lg_last [3][20];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   patch_streamer #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .PAD(0), .MEM_LAT(1)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .mem_addr(addr0), .mem_rd(mrd[0]), .mem_data(md0), .patch_valid(pv[0]),
      .patch_ready(rdy[0]), .patch(pt[0]), .out_row(row0), .out_col(col0), .last(last[0]));

   patch_streamer #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .PAD(1), .MEM_LAT(1)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .mem_addr(addr1), .mem_rd(mrd[1]), .mem_data(md1), .patch_valid(pv[1]),
      .patch_ready(rdy[1]), .patch(pt[1]), .out_row(row1), .out_col(col1), .last(last[1]));

   patch_streamer #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .PAD(0), .MEM_LAT(2)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .mem_addr(addr2), .mem_rd(mrd[2]), .mem_data(md2), .patch_valid(pv[2]),
      .patch_ready(rdy[2]), .patch(pt[2]), .out_row(row2), .out_col(col2), .last(last[2]));

   assign a_i[0] = int'(addr0);
   assign a_i[1] = int'(addr1);
   assign a_i[2] = int'(addr2);
   assign r_i[0] = int'(row0);
   assign r_i[1] = int'(row1);
   assign r_i[2] = int'(row2);
   assign c_i[0] = int'(col0);
   assign c_i[1] = int'(col1);
   assign c_i[2] = int'(col2);

   // Non-read cycles return 8'hEE so a pad slot loaded from the bus shows up.
   always @(posedge clk) begin
      md0 <= mrd[0] ? 8'(addr0) : 8'hEE;
      md1 <= mrd[1] ? 8'(addr1) : 8'hEE;
      m2a <= mrd[2] ? 8'(addr2) : 8'hEE;
      md2 <= m2a;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (clr) begin
            hs_cnt[i]   <= 0;
            done_cnt[i] <= 0;
            done_cyc[i] <= 0;
            first_pv[i] <= -1;
            max_addr[i] <= 0;
            bad_cnt[i]  <= 0;
         end else begin
            if (mrd[i] && a_i[i] > max_addr[i]) max_addr[i] <= a_i[i];
            if ((!mrd[i] && a_i[i] != 0) || (last[i] && !pv[i])) bad_cnt[i] <= bad_cnt[i] + 1;
            if (pv[i] && first_pv[i] < 0) first_pv[i] <= cyc;
            if (pv[i] && rdy[i] && hs_cnt[i] < 20) begin
               lg_pt[i][hs_cnt[i]]   <= pt[i];
               lg_row[i][hs_cnt[i]]  <= r_i[i];
               lg_col[i][hs_cnt[i]]  <= c_i[i];
               lg_cyc[i][hs_cnt[i]]  <= cyc;
               lg_last[i][hs_cnt[i]] <= last[i];
               hs_cnt[i] <= hs_cnt[i] + 1;
            end
            if (done[i]) begin
               done_cnt[i] <= done_cnt[i] + 1;
               done_cyc[i] <= cyc;
            end
         end
      end
   end

   function automatic logic [71:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
      return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clr   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         rdy[i]   = 1'b0;
      end
      tick(); tick(); tick();
      chk("rst_ctl",   {busy[0], done[0], mrd[0], pv[0], last[0]}, 0);
      chk("rst_addr",  a_i[0], 0);
      chk("rst_pos",   r_i[0] * 16 + c_i[0], 0);
      chk("rst_patch", pt[0], 0);
      reset = 1'b0;
      clr   = 1'b0;
      tick();

      // Full scans on all three configurations, consumer always ready.
      for (int i = 0; i < 3; i++) begin
         rdy[i]   = 1'b1;
         start[i] = 1'b1;
      end
      tick();
      s0 = cyc;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      for (int n = 0; n < 400 && (done_cnt[0] == 0 || done_cnt[1] == 0 || done_cnt[2] == 0); n++) tick();
      tick(); tick(); tick();

      chk("A0_first_lat", first_pv[0] - s0 + 1, 11);
      chk("A0_npatch",    hs_cnt[0], 4);
      chk("A0_p00",       lg_pt[0][0], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("A0_p01",       lg_pt[0][1], pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("A0_p10",       lg_pt[0][2], pk(4, 5, 6, 8, 9, 10, 12, 13, 14));
      chk("A0_p11",       lg_pt[0][3], pk(5, 6, 7, 9, 10, 11, 13, 14, 15));
      chk("A0_pos10",     lg_row[0][2] * 16 + lg_col[0][2], 16);
      chk("A0_pos11",     lg_row[0][3] * 16 + lg_col[0][3], 17);
      chk("A0_last11",    lg_last[0][3], 1);
      chk("A0_last10",    lg_last[0][2], 0);
      chk("A0_gap",       lg_cyc[0][1] - lg_cyc[0][0], 11);
      chk("A0_done_cyc",  done_cyc[0] - lg_cyc[0][3], 1);
      chk("A0_done_cnt",  done_cnt[0], 1);
      chk("A0_idle",      busy[0], 0);
      chk("A0_protocol",  bad_cnt[0], 0);

      chk("A1_npatch",    hs_cnt[1], 16);
      chk("A1_p00",       lg_pt[1][0],  pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
      chk("A1_p11",       lg_pt[1][5],  pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("A1_p33",       lg_pt[1][15], pk(10, 11, 0, 14, 15, 0, 0, 0, 0));
      chk("A1_pos33",     lg_row[1][15] * 16 + lg_col[1][15], 51);
      chk("A1_last33",    lg_last[1][15], 1);
      chk("A1_last32",    lg_last[1][14], 0);
      chk("A1_max_addr",  max_addr[1], 15);
      chk("A1_protocol",  bad_cnt[1], 0);

      chk("A2_first_lat", first_pv[2] - s0 + 1, 12);
      chk("A2_npatch",    hs_cnt[2], 4);
      chk("A2_p01",       lg_pt[2][1], pk(2, 3, 4, 7, 8, 9, 12, 13, 14));
      chk("A2_p10",       lg_pt[2][2], pk(10, 11, 12, 15, 16, 17, 20, 21, 22));
      chk("A2_p11",       lg_pt[2][3], pk(12, 13, 14, 17, 18, 19, 22, 23, 24));
      chk("A2_pos01",     lg_row[2][1] * 16 + lg_col[2][1], 1);
      chk("A2_gap",       lg_cyc[2][1] - lg_cyc[2][0], 12);
      chk("A2_max_addr",  max_addr[2], 24);

      // Back-pressure on the first patch.
      clear_logs();
      rdy[0]   = 1'b0;
      start[0] = 1'b1;
      tick();
      s0 = cyc;
      start[0] = 1'b0;
      for (int n = 0; n < 50 && !pv[0]; n++) tick();
      chk("B_lat", cyc - s0 + 1, 11);
      for (int k = 0; k < 5; k++) begin
         chk("B_valid", pv[0], 1);
         chk("B_patch", pt[0], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
         chk("B_pos",   r_i[0] * 16 + c_i[0], 0);
         chk("B_rd",    mrd[0], 0);
         tick();
      end
      rdy[0] = 1'b1;
      for (int n = 0; n < 100 && done_cnt[0] == 0; n++) tick();
      chk("B_npatch", hs_cnt[0], 4);
      chk("B_p11",    lg_pt[0][3], pk(5, 6, 7, 9, 10, 11, 13, 14, 15));

      // Reset in the middle of fetching the second patch, then rescan.
      clear_logs();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int n = 0; n < 50 && hs_cnt[0] < 2; n++) tick();
      tick(); tick(); tick();
      chk("C_pre_rd", {busy[0], mrd[0]}, 2'b11);
      reset = 1'b1;
      tick();
      chk("C_rst_ctl",   {busy[0], done[0], mrd[0], pv[0], last[0]}, 0);
      chk("C_rst_addr",  a_i[0], 0);
      chk("C_rst_pos",   r_i[0] * 16 + c_i[0], 0);
      chk("C_rst_patch", pt[0], 0);
      reset = 1'b0;
      tick();
      chk("C_drop", pt[0], 0);
      clear_logs();
      start[0] = 1'b1;
      tick();
      s0 = cyc;
      start[0] = 1'b0;
      for (int n = 0; n < 100 && done_cnt[0] == 0; n++) tick();
      chk("C_first_lat", first_pv[0] - s0 + 1, 11);
      chk("C_p00",       lg_pt[0][0], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("C_npatch",    hs_cnt[0], 4);

      // Start held high through an entire scan.
      clear_logs();
      start[0] = 1'b1;
      tick();
      for (int n = 0; n < 100 && !done[0]; n++) tick();
      chk("D_done",     done[0], 1);
      chk("D_npatch",   hs_cnt[0], 4);
      tick();
      chk("D_idle",     {busy[0], done[0]}, 0);
      chk("D_done_cnt", done_cnt[0], 1);
      tick();
      chk("D_restart",  busy[0], 1);
      start[0] = 1'b0;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
